obc_da_engine: RTL and testbench

OBC_DA_ENGINE -- requirements
Module: obc_da_engine

---
 rtl/obc_da_engine.sv | 85 ++++++++
 tb/tb_obc_da_engine.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/obc_da_engine.sv
// obc_da_engine: offset-binary-coded distributed-arithmetic dot product engine.
// One sample bit-plane is processed per RUN cycle, MSB first, then OFFSET is added.
module obc_da_engine #(
    parameter int N_PAIRS = 4,
    parameter int IN_W = 8,
    parameter int COEF_W = 32,
    localparam int ACC_W = COEF_W + $clog2(N_PAIRS) + IN_W + 1,
    localparam int AW = $clog2(2 * N_PAIRS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic [AW-1:0]               cfg_addr,
    input  logic [COEF_W-1:0]           cfg_data,
    input  logic                        start,
    input  logic [2*N_PAIRS*IN_W-1:0]   x_in,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            y_out
);
    localparam int JW = $clog2(IN_W);
    typedef enum logic [1:0] {IDLE, RUN, OFFS, DONE} state_t;
    state_t state;
    logic [COEF_W-1:0] coef [N_PAIRS][2];
    logic [COEF_W-1:0] offset;
    logic [2*N_PAIRS*IN_W-1:0] xr;
    logic [JW-1:0] j;
    logic signed [ACC_W-1:0] acc, p;
    always_comb begin
        p = '0;
        for (int g = 0; g < N_PAIRS; g++)
            p = p + ACC_W'(signed'(coef[g][xr[2*g*IN_W + int'(j)] ^ xr[(2*g+1)*IN_W + int'(j)]]));
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc <= '0;
            j <= JW'(IN_W - 1);
            xr <= '0;
            offset <= '0;
            for (int g = 0; g < N_PAIRS; g++) begin
                coef[g][0] <= '0;
                coef[g][1] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        if (cfg_addr == AW'(2 * N_PAIRS))
                            offset <= cfg_data;
                        for (int g = 0; g < N_PAIRS; g++)
                            for (int s = 0; s < 2; s++)
                                if (cfg_addr == AW'(2 * g + s))
                                    coef[g][s] <= cfg_data;
                    end
                    if (start) begin
                        xr <= x_in;
                        acc <= '0;
                        j <= JW'(IN_W - 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    // The MSB plane carries negative weight in two's complement.
                    acc <= (j == JW'(IN_W - 1)) ? (acc <<< 1) - p : (acc <<< 1) + p;
                    j <= (j == '0) ? JW'(IN_W - 1) : j - 1'b1;
                    if (j == '0)
                        state <= OFFS;
                end
                OFFS: begin
                    acc <= acc + ACC_W'(signed'(offset));
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
            endcase
        end
    end
    assign busy = state != IDLE;
    assign out_valid = state == DONE;
    assign y_out = acc;
endmodule

// File: tb/tb_obc_da_engine.sv
// tb_obc_da_engine: directed vectors with a result scoreboard for obc_da_engine.
module tb_obc_da_engine;
    localparam int N = 4;
    localparam int IW = 8;
    localparam int CW = 32;
    localparam int AW = CW + $clog2(N) + IW + 1;
    localparam int CA = $clog2(2 * N + 1);

    logic clk = 0, rst_n = 0, cfg_we = 0, start = 0, out_ready = 1;
    logic [CA-1:0] cfg_addr = '0;
    logic [CW-1:0] cfg_data = '0;
    logic [2*N*IW-1:0] x_in = '0;
    logic busy, out_valid;
    logic [AW-1:0] y_out;
    int checks = 0, errors = 0;
    logic [AW-1:0] sb [$];

    always #5 clk = ~clk;

    obc_da_engine dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .x_in(x_in), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .y_out(y_out)
    );

    task automatic chk(input string n, input logic [AW-1:0] a, input logic [AW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, $signed(a), $signed(e));
        end
    endtask

    // Scoreboard monitor: every accepted result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0d expected none", $signed(y_out));
            end else begin
                chk("result", y_out, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int a, input logic [CW-1:0] d);
        cfg_we = 1;
        cfg_addr = CA'(a);
        cfg_data = d;
        step();
        cfg_we = 0;
    endtask

    function automatic logic [2*N*IW-1:0] mk(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic launch(input logic [2*N*IW-1:0] x, input int e);
        start = 1;
        x_in = x;
        step();
        start = 0;
        x_in = ~x;
        sb.push_back(AW'(e));
        chk("busy_run", AW'(busy), AW'(1));
    endtask

    task automatic wait_valid(input int c0);
        int c = c0;
        while (!out_valid && c < 40) begin
            step();
            c++;
        end
        chk("latency", AW'(c), AW'(IW + 2));
        if (out_ready) begin
            step();
            chk("idle_after", AW'({busy, out_valid}), AW'(0));
        end
    endtask

    task automatic run(input logic [2*N*IW-1:0] x, input int e);
        launch(x, e);
        wait_valid(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk("rst_busy", AW'(busy), AW'(0));
        chk("rst_valid", AW'(out_valid), AW'(0));
        chk("rst_y", y_out, AW'(0));
        rst_n = 1;
        for (int g = 0; g < N; g++) cfg(2 * g + 1, 1);
        run(mk(8'h05, 0, 0, 0), 5);
        run(mk(8'hFF, 0, 0, 0), -1);
        cfg(8, 32'h1234);
        run(mk(8'h55, 8'h55, 0, 0), 32'h1234);
        run(mk(8'h05, 0, 8'h0F, 8'hF0), 32'h1238);
        cfg(8, 0);
        cfg(9, 32'h55);
        cfg(15, 32'h77);
        run(mk(8'h05, 0, 0, 0), 5);
        // Stall in DONE: output must hold and start pulses must be ignored.
        out_ready = 0;
        launch(mk(8'h05, 0, 0, 0), 5);
        wait_valid(1);
        for (int i = 0; i < 5; i++) begin
            start = 1;
            step();
            chk("hold_valid", AW'(out_valid), AW'(1));
            chk("hold_y", y_out, AW'(5));
        end
        start = 0;
        out_ready = 1;
        step();
        chk("hold_release", AW'({busy, out_valid}), AW'(0));
        launch(mk(8'h05, 0, 0, 0), 5);
        cfg(1, 9);
        wait_valid(2);
        cfg(0, 7);
        run(mk(8'h80, 0, 0, 0), 761);
        cfg(0, 0);
        cfg(1, -3);
        run(mk(8'h05, 0, 0, 0), -15);
        // Reset in the 4th RUN cycle abandons the run and clears the table.
        start = 1;
        x_in = mk(8'h05, 0, 0, 0);
        step();
        start = 0;
        step();
        step();
        step();
        rst_n = 0;
        step();
        chk("midrst_busy", AW'(busy), AW'(0));
        chk("midrst_valid", AW'(out_valid), AW'(0));
        chk("midrst_y", y_out, AW'(0));
        rst_n = 1;
        run(mk(8'h05, 0, 0, 0), 0);
        step();
        step();
        chk("sb_empty", AW'(sb.size()), AW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
